sys_weight_reader: RTL and testbench

SYS_WEIGHT_READER -- requirements
Module: sys_weight_reader

---
 rtl/sys_pkg.sv | 25 ++
 rtl/sys_weight_reader_if.sv | 48 ++++
 rtl/sys_skew_mux.sv | 39 +++
 rtl/sys_weight_reader.sv | 154 +++++++++++++++
 tb/tb_sys_weight_reader.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sys_pkg.sv
// -----------------------------------------------------------------------------
// sys_pkg
// Shared constants and types for the systolic weight reader.
//   N            : systolic array dimension (only 3 is supported)
//   BEATS        : beats per matrix on the skewed column feed (2N-1)
//   FETCH_CYCLES : FETCH length: N*N read strobes plus one drain cycle
//   K_W / T_W    : widths of the fetch counter k and beat counter t
//   state_e      : reader FSM states
// -----------------------------------------------------------------------------
package sys_pkg;

  localparam int N            = 3;
  localparam int BEATS        = 2 * N - 1;
  localparam int FETCH_CYCLES = N * N + 1;
  localparam int K_W          = $clog2(FETCH_CYCLES);
  localparam int T_W          = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM,
    DONE
  } state_e;

endpackage : sys_pkg

// File: rtl/sys_weight_reader_if.sv
// -----------------------------------------------------------------------------
// sys_weight_reader_if
// Groups the request, weight-RAM and column-feed signals of the reader.
//   start/base_addr      : load request and RAM address of b11
//   ram_addr/ram_re/ram_q: weight-RAM read port (data one cycle after strobe)
//   col0..col2/out_valid/out_ready : skewed column feed with handshake
//   busy/done            : status
//   csum                 : only present when SYS_RD_CHECKSUM_EN is defined
// Modports: master = the reader, slave = its environment.
// -----------------------------------------------------------------------------
interface sys_weight_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] col0;
  logic [DATA_W-1:0] col1;
  logic [DATA_W-1:0] col2;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
`ifdef SYS_RD_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  modport master (
    input  start, base_addr, ram_q, out_ready,
    output ram_addr, ram_re, col0, col1, col2, out_valid, busy, done
`ifdef SYS_RD_CHECKSUM_EN
    , output csum
`endif
  );

  modport slave (
    output start, base_addr, ram_q, out_ready,
    input  ram_addr, ram_re, col0, col1, col2, out_valid, busy, done
`ifdef SYS_RD_CHECKSUM_EN
    , input csum
`endif
  );

endinterface : sys_weight_reader_if

// File: rtl/sys_skew_mux.sv
// -----------------------------------------------------------------------------
// sys_skew_mux
// Combinational skew network: column j shows w[t-j][j] while 0 <= t-j <= N-1,
// otherwise 0, so each column's diagonal starts one beat after its neighbour.
//   w_i    : N*N weights, row-major (w_i[r*N+c] = w[r][c])
//   t_i    : beat index 0..2N-2
//   col*_o : column feeds 0..2
// -----------------------------------------------------------------------------
module sys_skew_mux
  import sys_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [N*N-1:0][DATA_W-1:0] w_i,
  input  logic [T_W-1:0]             t_i,
  output logic [DATA_W-1:0]          col0_o,
  output logic [DATA_W-1:0]          col1_o,
  output logic [DATA_W-1:0]          col2_o
);

  logic [N-1:0][DATA_W-1:0] col;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    col = '0;
    for (int j = 0; j < N; j++) begin
      for (int r = 0; r < N; r++) begin
        // Row r of column j is presented on beat t = r + j.
        if (int'(t_i) == r + j) col[j] = w_i[r*N + j];
      end
    end
  end

  assign col0_o = col[0];
  assign col1_o = col[1];
  assign col2_o = col[2];

endmodule : sys_skew_mux

// File: rtl/sys_weight_reader.sv
// -----------------------------------------------------------------------------
// sys_weight_reader
// Fetches one 3x3 weight matrix (row-major at base_addr..base_addr+8, address
// wrapping mod 2^ADDR_W) from a one-cycle-latency RAM, then streams it to the
// systolic array as 5 skewed beats under a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sys_weight_reader_if.master (request, RAM port, column feed)
// Optional feature: define SYS_RD_CHECKSUM_EN to add bus.csum, the modulo
// 2^DATA_W sum of the nine captured weights.
// Timing: start seen -> FETCH k=0..9 (reads on k=0..8, capture on k=1..9)
// -> STREAM t=0..4 -> DONE (one-cycle done) -> IDLE.
// -----------------------------------------------------------------------------
module sys_weight_reader
  import sys_pkg::state_e, sys_pkg::IDLE, sys_pkg::FETCH, sys_pkg::STREAM,
         sys_pkg::DONE, sys_pkg::BEATS, sys_pkg::K_W, sys_pkg::T_W;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int N      = 3   // only 3 is supported
) (
  input logic                 clk,
  input logic                 rst_n,
  sys_weight_reader_if.master bus
);

  localparam int NUM_W = N * N;

  state_e                     state_q, state_d;
  logic [K_W-1:0]             k_q, k_d;
  logic [T_W-1:0]             t_q, t_d;
  logic [ADDR_W-1:0]          base_q, base_d;
  logic [NUM_W-1:0][DATA_W-1:0] w_q, w_d;

  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic              out_valid;
  logic              done;
  logic [DATA_W-1:0] mux_col0, mux_col1, mux_col2;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    t_d       = t_q;
    base_d    = base_q;
    w_d       = w_q;
    ram_re    = 1'b0;
    ram_addr  = '0;
    out_valid = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          k_d     = '0;
          base_d  = bus.base_addr;
        end
      end

      FETCH: begin
        if (k_q < K_W'(NUM_W)) begin
          ram_re   = 1'b1;
          ram_addr = base_q + ADDR_W'(k_q);
        end
        // RAM data trails its strobe by one cycle, so cycle k holds word k-1.
        if (k_q != '0) w_d[k_q - 1'b1] = bus.ram_q;
        if (k_q == K_W'(NUM_W)) begin
          state_d = STREAM;
          t_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      STREAM: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (t_q == T_W'(BEATS - 1)) state_d = DONE;
          else                        t_d     = t_q + 1'b1;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      t_q     <= '0;
      base_q  <= '0;
      // NOTE: the weight store is nine flops, not a RAM macro, so resetting
      // it is cheap and keeps csum and the column feed clean after reset.
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      base_q  <= base_d;
      w_q     <= w_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Skewed column feed, forced to zero whenever no beat is offered
  // ---------------------------------------------------------------------------
  sys_skew_mux #(
    .DATA_W (DATA_W)
  ) u_skew_mux (
    .w_i    (w_q),
    .t_i    (t_q),
    .col0_o (mux_col0),
    .col1_o (mux_col1),
    .col2_o (mux_col2)
  );

  assign bus.col0      = out_valid ? mux_col0 : '0;
  assign bus.col1      = out_valid ? mux_col1 : '0;
  assign bus.col2      = out_valid ? mux_col2 : '0;
  assign bus.out_valid = out_valid;
  assign bus.ram_re    = ram_re;
  assign bus.ram_addr  = ram_addr;
  assign bus.done      = done;
  assign bus.busy      = (state_q != IDLE);

`ifdef SYS_RD_CHECKSUM_EN
  // Sum of the weight store; complete from STREAM entry until the next
  // FETCH starts overwriting it.
  logic [DATA_W-1:0] csum;

  always_comb begin
    csum = '0;
    for (int i = 0; i < NUM_W; i++) csum = csum + w_q[i];
  end

  assign bus.csum = csum;
`endif

endmodule : sys_weight_reader

// File: tb/tb_sys_weight_reader.sv
// -----------------------------------------------------------------------------
// tb_sys_weight_reader
// Directed bench for sys_weight_reader: plain load, wrapping base address,
// back-pressure, start during STREAM, reset mid-FETCH and (with
// SYS_RD_CHECKSUM_EN) the checksum output. Expected beats are hand-computed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sys_weight_reader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  logic clk;
  logic rst_n;

  sys_weight_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sys_weight_reader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .N      (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight RAM model: data appears one cycle after the read strobe.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always @(posedge clk) begin
    if (bus.ram_re) bus.ram_q <= mem[bus.ram_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0]       exp_b [5];
  logic [DATA_W-1:0] exp_csum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] first);
    for (int i = 0; i < 9; i++) mem[base + ADDR_W'(i)] = first + DATA_W'(i);
  endtask

  // Starts a transfer, checks the fetch address sequence, the 11-cycle
  // latency, every beat (including held beats) and the single done pulse.
  task automatic run_transfer(input logic [ADDR_W-1:0] base, input bit toggle_ready,
                              input bit inject_start);
    logic [ADDR_W-1:0] ea;
    int beat;
    int cyc;
    bit injected;

    bus.base_addr = base;
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.base_addr = '0;

    for (int k = 0; k < 10; k++) begin
      if (k <= 8) begin
        ea = base + ADDR_W'(k);
        check($sformatf("fetch_re_k%0d", k), 32'(bus.ram_re), 32'd1);
        check($sformatf("fetch_addr_k%0d", k), 32'(bus.ram_addr), 32'(ea));
      end else begin
        check("fetch_re_k9", 32'(bus.ram_re), 32'd0);
      end
      if (k == 0) check("fetch_busy", 32'(bus.busy), 32'd1);
      check($sformatf("fetch_valid_k%0d", k), 32'(bus.out_valid), 32'd0);
      step();
    end

    check("first_beat_latency", 32'(bus.out_valid), 32'd1);
`ifdef SYS_RD_CHECKSUM_EN
    check("csum", 32'(bus.csum), 32'(exp_csum));
`endif

    beat     = 0;
    cyc      = 0;
    injected = 1'b0;
    while (beat < 5 && cyc < 40) begin
      bus.out_ready = toggle_ready ? ((cyc % 2) == 1) : 1'b1;
      if (inject_start && beat == 2 && !injected) begin
        bus.start     = 1'b1;
        bus.base_addr = 6'd20;
        injected      = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      check($sformatf("stream_valid_b%0d", beat), 32'(bus.out_valid), 32'd1);
      check($sformatf("beat%0d", beat), {8'h0, bus.col0, bus.col1, bus.col2},
            {8'h0, exp_b[beat]});
      check("stream_done_low", 32'(bus.done), 32'd0);
      if (bus.out_ready) beat++;
      step();
      cyc++;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    check("beats_delivered", 32'(beat), 32'd5);

    check("done_pulse", 32'(bus.done), 32'd1);
    check("done_valid_low", 32'(bus.out_valid), 32'd0);
    check("done_cols_zero", {8'h0, bus.col0, bus.col1, bus.col2}, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      check("post_done_low", 32'(bus.done), 32'd0);
      check("post_busy_low", 32'(bus.busy), 32'd0);
      step();
    end
  endtask

  task automatic set_beats_1_9();
    exp_b = '{24'h010000, 24'h040200, 24'h070503, 24'h000806, 24'h000009};
    exp_csum = 8'd45;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_re"}, 32'(bus.ram_re), 32'd0);
    check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_cols"}, {8'h0, bus.col0, bus.col1, bus.col2}, 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
`ifdef SYS_RD_CHECKSUM_EN
    check({tag, "_csum"}, 32'(bus.csum), 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    bus.ram_q     = '0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    exp_csum      = '0;
    exp_b         = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0};

    repeat (2) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Plain load, RAM[0..8] = 1..9.
    load_seq(6'd0, 8'd1);
    set_beats_1_9();
    run_transfer(6'd0, 1'b0, 1'b0);

    // Wrapping base: RAM[62,63,0..6] = 10..18.
    load_seq(6'd62, 8'd10);
    exp_b = '{24'h0A0000, 24'h0D0B00, 24'h100E0C, 24'h00110F, 24'h000012};
    exp_csum = 8'd126;
    run_transfer(6'd62, 1'b0, 1'b0);

    // Back-pressure: ready low on alternate cycles.
    load_seq(6'd0, 8'd1);
    set_beats_1_9();
    run_transfer(6'd0, 1'b1, 1'b0);

    // start pulsed during STREAM is ignored.
    run_transfer(6'd0, 1'b0, 1'b1);

    // Reset at FETCH k=5 abandons the transfer.
    bus.base_addr = 6'd0;
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check_all_zero("midfetch_reset");
    #2;
    rst_n = 1'b1;
    step();
    check("after_reset_done", 32'(bus.done), 32'd0);
    run_transfer(6'd0, 1'b0, 1'b0);

`ifdef SYS_RD_CHECKSUM_EN
    // All weights 0xFF: 9 * 255 mod 256 = 0xF7.
    for (int i = 0; i < 9; i++) mem[10 + i] = 8'hFF;
    exp_b = '{24'hFF0000, 24'hFFFF00, 24'hFFFFFF, 24'h00FFFF, 24'h0000FF};
    exp_csum = 8'hF7;
    run_transfer(6'd10, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sys_weight_reader
